ecc_dec_ctrl: RTL and testbench
===============================

Name: ecc_dec_ctrl

Overview:
Sequencing controller for the ECC decode path. It accepts codewords and a work mode over a valid/ready handshake. It runs the external syndrome unit, then holds the DEC_CHK inputs stable for that block's two-edge latency and captures the corrected word and error class. Results go out on a valid/ready handshake, and saturating error statistics are kept for the register file.

Parameters:
MAX_CODEWORD_WIDTH, 32, codeword width.
MAX_PARITY_WIDTH, 6, syndrome width.
SYN_TIMEOUT, 64, maximum cycles to wait for syn_done.
CNT_WIDTH, 16, width of each statistics counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  input codeword valid.
in_ready  out  1  controller can accept a codeword.
in_data  in  32  received codeword.
in_mode  in  2  work mode: 0 = (8,4), 1 = (16,11), 2 = (32,26), 3 = illegal.
syn_start  out  1  one-cycle start pulse to the syndrome unit.
syn_data  out  32  masked codeword to the syndrome unit.
syn_mode  out  2  mode to the syndrome unit.
syn_done  in  1  syndrome valid.
syn_vector  in  6  syndrome result.
chk_data  out  32  DEC_CHK data_in.
chk_s_vector  out  6  DEC_CHK s_vector.
chk_work_mod  out  2  DEC_CHK work_mod.
chk_data_out  in  32  DEC_CHK data_out.
chk_num_errors  in  2  DEC_CHK num_of_errors.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  32  corrected codeword.
out_errors  out  2  error class: 00 none, 01 corrected, 10 uncorrectable, 11 illegal mode or timeout.
stat_clr  in  1  synchronous clear of all counters.
cnt_total, cnt_corr, cnt_uncorr  out  CNT_WIDTH each  statistics counters.
timeout_flag  out  1  sticky syndrome-timeout flag; cleared by stat_clr.

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE.
  - in_ready, syn_start and out_valid are 0.
  - out_data, out_errors, chk_data, chk_s_vector, chk_work_mod, syn_data, syn_mode, all counters and timeout_flag are 0.
  - in_ready stays 0 while rst is high. A reset mid-operation abandons the transaction; no output is produced for it.
- FSM states: IDLE, SYN, CHK1, CHK2, CAP, OUT.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready, latch in_data masked to the mode length (mode 0 keeps bits 7:0, mode 1 keeps 15:0, mode 2 keeps 31:0; all other bits zero).
  - Mode 0–2: go to SYN. Mode 3: go to OUT with out_data = masked in_data and out_errors = 11; the syndrome unit and DEC_CHK are not used.
- SYN:
  - syn_start is high for exactly the first cycle of SYN. syn_data and syn_mode hold the latched values for the whole state.
  - syn_done is sampled from the first SYN cycle onward, so zero-latency units are allowed. On the edge with syn_done = 1, latch syn_vector and go to CHK1.
  - A wait counter starts at 0 on entry. If SYN_TIMEOUT cycles pass without syn_done: set timeout_flag, go to OUT with out_data = latched data and out_errors = 11.
- CHK1 → CHK2 → CAP, one cycle each: chk_data, chk_s_vector and chk_work_mod are held constant from CHK1 entry until CAP exits.
- CAP: on the edge ending CAP, capture chk_data_out → out_data and chk_num_errors → out_errors, then go to OUT.
- OUT:
  - out_valid = 1, and out_data/out_errors are stable until out_ready.
  - On an edge with out_valid & out_ready, go to IDLE and update counters.
- Latency: there is no new accept in the cycle of the output handshake. With zero-latency syn_done, acceptance to out_valid is 5 cycles.
- Counters, updated on the output handshake:
  - cnt_total always increments.
  - cnt_corr increments when out_errors = 01; cnt_uncorr increments when out_errors = 10. Class 11 increments only cnt_total.
  - Each counter saturates at all-ones with no wrap.
  - stat_clr wins over a simultaneous increment and also clears timeout_flag.
- syn_done or DEC_CHK inputs arriving outside their states are ignored.

Test Plan:
1. Reset mid-CHK2 (rst pulsed asynchronously) → immediate IDLE, out_valid = 0, counters 0; a following transaction completes normally.
2. Mode 2, in_data = 0x00000000, syn_vector = 0x00 with zero latency → out_data = 0x00000000, out_errors = 00, out_valid 5 cycles after acceptance, cnt_total = 1.
3. Mode 2, in_data = 0x00000000, syn_vector = 0x21 → out_data = 0x00000001, out_errors = 01, cnt_corr = 1. Then syn_vector = 0x03 → out_errors = 10, out_data unchanged, cnt_uncorr = 1.
4. Mode 0, in_data = 0xFFFFFF5A → syn_data = 0x0000005A. Mode 3 input → out_errors = 11, syn_start never asserted, only cnt_total increments.
5. syn_done withheld for 64 cycles → out_errors = 11, timeout_flag = 1. Then stat_clr → timeout_flag = 0 and counters 0.
6. out_ready held low 10 cycles with in_valid high → in_ready = 0 and outputs stable. Counters forced to 0xFFFF stay at 0xFFFF. stat_clr coincident with the handshake → counters 0.

Source files
------------

// File: rtl/ecc_dec_ctrl.sv
// Sequencing controller for the ECC decode path: drives the syndrome unit, holds
// the DEC_CHK inputs over its two-edge latency, and keeps saturating statistics.
module ecc_dec_ctrl #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_PARITY_WIDTH   = 6,
  parameter int SYN_TIMEOUT        = 64,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] in_data,
  input  logic [1:0]                    in_mode,
  output logic                          syn_start,
  output logic [MAX_CODEWORD_WIDTH-1:0] syn_data,
  output logic [1:0]                    syn_mode,
  input  logic                          syn_done,
  input  logic [MAX_PARITY_WIDTH-1:0]   syn_vector,
  output logic [MAX_CODEWORD_WIDTH-1:0] chk_data,
  output logic [MAX_PARITY_WIDTH-1:0]   chk_s_vector,
  output logic [1:0]                    chk_work_mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0] chk_data_out,
  input  logic [1:0]                    chk_num_errors,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
  output logic [1:0]                    out_errors,
  input  logic                          stat_clr,
  output logic [CNT_WIDTH-1:0]          cnt_total,
  output logic [CNT_WIDTH-1:0]          cnt_corr,
  output logic [CNT_WIDTH-1:0]          cnt_uncorr,
  output logic                          timeout_flag
);

  typedef enum logic [2:0] {IDLE, SYN, CHK1, CHK2, CAP, OUT} state_t;

  localparam int                WAIT_W       = $clog2(SYN_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(SYN_TIMEOUT - 1);
  localparam logic [1:0]        MODE_ILLEGAL = 2'd3;
  localparam logic [1:0]        ERR_CORR     = 2'b01;
  localparam logic [1:0]        ERR_UNCORR   = 2'b10;
  localparam logic [1:0]        ERR_ILLEGAL  = 2'b11;

  state_t                          state_q, state_d;
  logic [MAX_CODEWORD_WIDTH-1:0]   data_q, data_d;
  logic [1:0]                      mode_q, mode_d;
  logic [MAX_PARITY_WIDTH-1:0]     synVec_q, synVec_d;
  logic [MAX_CODEWORD_WIDTH-1:0]   outData_q, outData_d;
  logic [1:0]                      outErr_q, outErr_d;
  logic [WAIT_W-1:0]               waitCnt_q, waitCnt_d;
  logic [CNT_WIDTH-1:0]            cntTotal_q, cntTotal_d;
  logic [CNT_WIDTH-1:0]            cntCorr_q, cntCorr_d;
  logic [CNT_WIDTH-1:0]            cntUncorr_q, cntUncorr_d;
  logic                            timeout_q, timeout_d;

  logic accept;
  logic synTimeout;
  logic outFire;

  // Illegal mode has no defined code length, so the whole word is passed through.
  function automatic logic [MAX_CODEWORD_WIDTH-1:0] maskWord(
    input logic [MAX_CODEWORD_WIDTH-1:0] d,
    input logic [1:0]                    m
  );
    int keep;
    keep = (m == 2'd0) ? 8 : (m == 2'd1) ? 16 : MAX_CODEWORD_WIDTH;
    for (int i = 0; i < MAX_CODEWORD_WIDTH; i++) begin
      maskWord[i] = (i < keep) ? d[i] : 1'b0;
    end
  endfunction

  assign accept     = in_valid && in_ready;
  assign synTimeout = (state_q == SYN) && !syn_done && (waitCnt_q == WAIT_LAST);
  assign outFire    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (in_mode == MODE_ILLEGAL) ? OUT : SYN;
        end
      end
      SYN: begin
        if (syn_done) begin
          state_d = CHK1;
        end else if (synTimeout) begin
          state_d = OUT;
        end
      end
      CHK1:    state_d = CHK2;
      CHK2:    state_d = CAP;
      CAP:     state_d = OUT;
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is gated by rst so nothing is offered while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    syn_start = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = !rst;
      SYN:     syn_start = (waitCnt_q == '0);
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    mode_d    = mode_q;
    synVec_d  = synVec_q;
    outData_d = outData_q;
    outErr_d  = outErr_q;
    waitCnt_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = maskWord(in_data, in_mode);
          mode_d = in_mode;
          if (in_mode == MODE_ILLEGAL) begin
            outData_d = maskWord(in_data, in_mode);
            outErr_d  = ERR_ILLEGAL;
          end
        end
      end
      SYN: begin
        waitCnt_d = waitCnt_q + 1'b1;
        if (syn_done) begin
          synVec_d = syn_vector;
        end else if (synTimeout) begin
          outData_d = data_q;
          outErr_d  = ERR_ILLEGAL;
        end
      end
      CAP: begin
        outData_d = chk_data_out;
        outErr_d  = chk_num_errors;
      end
      default: ;
    endcase
  end

  // Clear has priority over any increment or timeout in the same cycle.
  always_comb begin
    cntTotal_d  = cntTotal_q;
    cntCorr_d   = cntCorr_q;
    cntUncorr_d = cntUncorr_q;
    timeout_d   = timeout_q;
    if (stat_clr) begin
      cntTotal_d  = '0;
      cntCorr_d   = '0;
      cntUncorr_d = '0;
      timeout_d   = 1'b0;
    end else begin
      if (synTimeout) begin
        timeout_d = 1'b1;
      end
      if (outFire) begin
        if (cntTotal_q != '1) begin
          cntTotal_d = cntTotal_q + 1'b1;
        end
        if ((outErr_q == ERR_CORR) && (cntCorr_q != '1)) begin
          cntCorr_d = cntCorr_q + 1'b1;
        end
        if ((outErr_q == ERR_UNCORR) && (cntUncorr_q != '1)) begin
          cntUncorr_d = cntUncorr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      mode_q      <= '0;
      synVec_q    <= '0;
      outData_q   <= '0;
      outErr_q    <= '0;
      waitCnt_q   <= '0;
      cntTotal_q  <= '0;
      cntCorr_q   <= '0;
      cntUncorr_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      data_q      <= data_d;
      mode_q      <= mode_d;
      synVec_q    <= synVec_d;
      outData_q   <= outData_d;
      outErr_q    <= outErr_d;
      waitCnt_q   <= waitCnt_d;
      cntTotal_q  <= cntTotal_d;
      cntCorr_q   <= cntCorr_d;
      cntUncorr_q <= cntUncorr_d;
      timeout_q   <= timeout_d;
    end
  end

  // The latched word/mode/syndrome only change outside CHK1..CAP, so DEC_CHK sees stable inputs.
  assign syn_data     = data_q;
  assign syn_mode     = mode_q;
  assign chk_data     = data_q;
  assign chk_s_vector = synVec_q;
  assign chk_work_mod = mode_q;
  assign out_data     = outData_q;
  assign out_errors   = outErr_q;
  assign cnt_total    = cntTotal_q;
  assign cnt_corr     = cntCorr_q;
  assign cnt_uncorr   = cntUncorr_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_ecc_dec_ctrl.sv
// Scoreboard bench for ecc_dec_ctrl with behavioural syndrome-unit and DEC_CHK models;
// a second instance with 3-bit counters exercises saturation.
module tb_ecc_dec_ctrl;

  localparam int SYN_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        syn_start;
  logic [31:0] syn_data;
  logic [1:0]  syn_mode;
  logic        syn_done;
  logic [5:0]  syn_vector;
  logic [31:0] chk_data;
  logic [5:0]  chk_s_vector;
  logic [1:0]  chk_work_mod;
  logic [31:0] chk_data_out;
  logic [1:0]  chk_num_errors;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_errors;
  logic        stat_clr = 1'b0;
  logic [15:0] cnt_total, cnt_corr, cnt_uncorr;
  logic        timeout_flag;

  logic        satInValid = 1'b0;
  logic [1:0]  satErr = 2'b01;
  logic        satClr = 1'b0;
  logic        satInReady, satSynStart, satOutValid, satTimeout;
  logic [31:0] satSynData, satChkData, satOutData;
  logic [1:0]  satSynMode, satChkMod, satOutErrors;
  logic [5:0]  satChkS;
  logic [2:0]  satTotal, satCorr, satUncorr;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  int acceptCycle = 0;
  int synLatency = 0;
  int synCount = 0;
  int synStartCnt = 0;
  bit synWithhold = 1'b0;
  logic [5:0]  synVecDrv = '0;
  logic [31:0] lastSynData = '0;
  logic [1:0]  lastSynMode = '0;
  logic [33:0] chkSt1 = '0, chkSt2 = '0;
  logic [33:0] expQ[$];
  logic [15:0] expTotal = '0, expCorr = '0, expUncorr = '0;
  logic        expTimeout = 1'b0;

  always #5 clk = ~clk;

  ecc_dec_ctrl #(.SYN_TIMEOUT(SYN_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .syn_start(syn_start), .syn_data(syn_data), .syn_mode(syn_mode),
    .syn_done(syn_done), .syn_vector(syn_vector), .chk_data(chk_data),
    .chk_s_vector(chk_s_vector), .chk_work_mod(chk_work_mod), .chk_data_out(chk_data_out),
    .chk_num_errors(chk_num_errors), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_errors(out_errors), .stat_clr(stat_clr),
    .cnt_total(cnt_total), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr),
    .timeout_flag(timeout_flag)
  );

  ecc_dec_ctrl #(.CNT_WIDTH(3)) satDut (
    .clk(clk), .rst(rst), .in_valid(satInValid), .in_ready(satInReady), .in_data(32'h0),
    .in_mode(2'd2), .syn_start(satSynStart), .syn_data(satSynData), .syn_mode(satSynMode),
    .syn_done(1'b1), .syn_vector(6'h00), .chk_data(satChkData),
    .chk_s_vector(satChkS), .chk_work_mod(satChkMod), .chk_data_out(32'h0),
    .chk_num_errors(satErr), .out_valid(satOutValid), .out_ready(1'b1),
    .out_data(satOutData), .out_errors(satOutErrors), .stat_clr(satClr),
    .cnt_total(satTotal), .cnt_corr(satCorr), .cnt_uncorr(satUncorr),
    .timeout_flag(satTimeout)
  );

  // SECDED-style reference: s[5] set = single error at bit s[4:0]-1, else nonzero = uncorrectable.
  function automatic logic [33:0] decModel(input logic [31:0] d, input logic [5:0] s);
    logic [31:0] r;
    int idx;
    r = d;
    if (s == 6'd0) return {2'b00, d};
    if (s[5]) begin
      idx = int'(s[4:0]) - 1;
      if (idx >= 0) r[idx] = ~r[idx];
      return {2'b01, r};
    end
    return {2'b10, d};
  endfunction

  assign syn_done = !synWithhold &&
                    (syn_start ? (synLatency == 0) : (synCount != 0 && synCount >= synLatency));
  assign syn_vector     = synVecDrv;
  assign chk_data_out   = chkSt2[31:0];
  assign chk_num_errors = chkSt2[33:32];

  always @(posedge clk) begin
    cycleNo <= cycleNo + 1;
    chkSt1  <= decModel(chk_data, chk_s_vector);
    chkSt2  <= chkSt1;
    if (syn_done) synCount <= 0;
    else if (syn_start) synCount <= 1;
    else if (synCount != 0) synCount <= synCount + 1;
    if (syn_start) begin
      synStartCnt <= synStartCnt + 1;
      lastSynData <= syn_data;
      lastSynMode <= syn_mode;
    end
  end

  task automatic sendWord(input logic [31:0] d, input logic [1:0] m, input logic [5:0] sv,
                          input int lat);
    int n;
    logic [31:0] masked;
    synVecDrv = sv;
    synLatency = lat;
    in_data = d;
    in_mode = m;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acceptCycle = cycleNo;
    in_valid = 1'b0;
    masked = (m == 2'd0) ? (d & 32'h0000_00FF) : (m == 2'd1) ? (d & 32'h0000_FFFF) : d;
    if (m == 2'd3 || synWithhold) expQ.push_back({2'b11, masked});
    else expQ.push_back(decModel(masked, sv));
  endtask

  task automatic recvWord(input string name, input int expLat, input int holdCycles,
                          input bit clrAtHs);
    int n;
    bit stable;
    logic [31:0] heldData;
    logic [1:0]  heldErr;
    logic [33:0] exp;
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s out_valid: got %b after %0d cycles, required 1", name, out_valid, n);
      if (expQ.size() > 0) exp = expQ.pop_front();
      return;
    end
    if (expLat >= 0) begin
      checks++;
      if (cycleNo - acceptCycle + 1 != expLat) begin
        errors++;
        $display("[TB] FAIL %s latency: got %0d, required %0d", name,
                 cycleNo - acceptCycle + 1, expLat);
      end
    end
    heldData = out_data;
    heldErr = out_errors;
    stable = 1'b1;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== heldData ||
          out_errors !== heldErr) stable = 1'b0;
    end
    if (holdCycles > 0) begin
      checks++;
      if (!stable) begin
        errors++;
        $display("[TB] FAIL %s hold: outputs changed or in_ready rose (now data=%h err=%b rdy=%b), required stable %h/%b",
                 name, out_data, out_errors, in_ready, heldData, heldErr);
      end
    end
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard: got output %h/%b, required none", name, out_data, out_errors);
    end else begin
      exp = expQ.pop_front();
      if (out_data !== exp[31:0]) begin
        errors++;
        $display("[TB] FAIL %s data: got %h, required %h", name, out_data, exp[31:0]);
      end
      checks++;
      if (out_errors !== exp[33:32]) begin
        errors++;
        $display("[TB] FAIL %s errors: got %b, required %b", name, out_errors, exp[33:32]);
      end
      if (clrAtHs) begin
        expTotal = '0; expCorr = '0; expUncorr = '0; expTimeout = 1'b0;
      end else begin
        if (expTotal != 16'hFFFF) expTotal++;
        if (exp[33:32] == 2'b01 && expCorr != 16'hFFFF) expCorr++;
        if (exp[33:32] == 2'b10 && expUncorr != 16'hFFFF) expUncorr++;
      end
    end
    out_ready = 1'b1;
    stat_clr = clrAtHs;
    @(posedge clk); #1;
    out_ready = 1'b0;
    stat_clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s post_handshake: got valid=%b ready=%b, required valid=0 ready=1",
               name, out_valid, in_ready);
    end
    checks++;
    if (cnt_total !== expTotal || cnt_corr !== expCorr || cnt_uncorr !== expUncorr) begin
      errors++;
      $display("[TB] FAIL %s counters: got %0d/%0d/%0d, required %0d/%0d/%0d", name,
               cnt_total, cnt_corr, cnt_uncorr, expTotal, expCorr, expUncorr);
    end
    checks++;
    if (timeout_flag !== expTimeout) begin
      errors++;
      $display("[TB] FAIL %s timeout_flag: got %b, required %b", name, timeout_flag, expTimeout);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || syn_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset handshake: got rdy=%b vld=%b start=%b, required 0/0/0",
               in_ready, out_valid, syn_start);
    end
    checks++;
    if (out_data !== 32'h0 || out_errors !== 2'b00 || chk_data !== 32'h0 ||
        chk_s_vector !== 6'h0 || chk_work_mod !== 2'b00 || syn_data !== 32'h0 || syn_mode !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset datapath: got out=%h/%b chk=%h/%h/%b syn=%h/%b, required all 0",
               out_data, out_errors, chk_data, chk_s_vector, chk_work_mod, syn_data, syn_mode);
    end
    checks++;
    if (cnt_total !== 16'h0 || cnt_corr !== 16'h0 || cnt_uncorr !== 16'h0 || timeout_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset stats: got %0d/%0d/%0d/%b, required 0/0/0/0",
               cnt_total, cnt_corr, cnt_uncorr, timeout_flag);
    end
    #10 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset release: in_ready got %b, required 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    sendWord(32'h1234_5678, 2'd2, 6'h00, 0);
    recvWord("pre_reset", 5, 0, 1'b0);
    sendWord(32'hCAFE_0000, 2'd2, 6'h21, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || cnt_total !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got vld=%b rdy=%b total=%0d, required 0/0/0",
               out_valid, in_ready, cnt_total);
    end
    expQ.delete();
    expTotal = '0; expCorr = '0; expUncorr = '0; expTimeout = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_after: got vld=%b rdy=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero();
    sendWord(32'h0000_0000, 2'd2, 6'h00, 0);
    recvWord("zero", 5, 0, 1'b0);
  endtask

  task automatic test_correction();
    sendWord(32'h0000_0000, 2'd2, 6'h21, 0);
    recvWord("corrected", 5, 0, 1'b0);
    sendWord(32'h0000_0000, 2'd2, 6'h03, 1);
    recvWord("uncorrectable", 6, 0, 1'b0);
  endtask

  task automatic test_modes();
    int startCnt;
    startCnt = synStartCnt;
    sendWord(32'hFFFF_FF5A, 2'd0, 6'h00, 2);
    recvWord("mode0", 7, 0, 1'b0);
    checks++;
    if (lastSynData !== 32'h0000_005A || lastSynMode !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mode0 syn_data: got %h/%0d, required 0000005a/0", lastSynData, lastSynMode);
    end
    checks++;
    if (synStartCnt - startCnt != 1) begin
      errors++;
      $display("[TB] FAIL syn_start pulse: got %0d cycles, required 1", synStartCnt - startCnt);
    end
    sendWord(32'hABCD_1234, 2'd1, 6'h25, 0);
    recvWord("mode1", 5, 0, 1'b0);
    startCnt = synStartCnt;
    sendWord(32'hDEAD_BEEF, 2'd3, 6'h21, 0);
    recvWord("mode3", 1, 0, 1'b0);
    checks++;
    if (synStartCnt != startCnt) begin
      errors++;
      $display("[TB] FAIL mode3 syn_start: got %0d pulses, required 0", synStartCnt - startCnt);
    end
  endtask

  task automatic test_timeout();
    synWithhold = 1'b1;
    sendWord(32'h0F0F_0F0F, 2'd2, 6'h21, 0);
    expTimeout = 1'b1;
    recvWord("timeout", SYN_TIMEOUT + 1, 0, 1'b0);
    synWithhold = 1'b0;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    expTotal = '0; expCorr = '0; expUncorr = '0; expTimeout = 1'b0;
    checks++;
    if (timeout_flag !== 1'b0 || cnt_total !== 16'h0 || cnt_corr !== 16'h0 || cnt_uncorr !== 16'h0) begin
      errors++;
      $display("[TB] FAIL stat_clr: got flag=%b cnt=%0d/%0d/%0d, required 0/0/0/0",
               timeout_flag, cnt_total, cnt_corr, cnt_uncorr);
    end
  endtask

  task automatic test_backpressure();
    sendWord(32'h5555_AAAA, 2'd2, 6'h00, 0);
    in_data = 32'h1234_5678;
    in_mode = 2'd2;
    in_valid = 1'b1;
    recvWord("backpressure", 5, 10, 1'b0);
    sendWord(32'h1234_5678, 2'd2, 6'h3F, 3);
    recvWord("clear_at_handshake", 8, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] svTab [6];
    int lat;
    svTab = '{6'h00, 6'h21, 6'h2A, 6'h03, 6'h20, 6'h3F};
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(0, 3);
      sendWord($urandom, 2'($urandom_range(0, 2)), svTab[i], lat);
      recvWord("back_to_back", 5 + lat, 0, 1'b0);
    end
  endtask

  task automatic test_saturation();
    int n;
    satErr = 2'b01;
    satInValid = 1'b1;
    repeat (60) @(posedge clk);
    #1 satErr = 2'b10;
    repeat (60) @(posedge clk);
    #1 satInValid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (satTotal !== 3'd7 || satCorr !== 3'd7 || satUncorr !== 3'd7) begin
      errors++;
      $display("[TB] FAIL saturation: got %0d/%0d/%0d, required 7/7/7", satTotal, satCorr, satUncorr);
    end
    satInValid = 1'b1;
    n = 0;
    while (satOutValid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (satOutValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat out_valid: got %b, required 1", satOutValid);
    end
    satClr = 1'b1;
    @(posedge clk); #1;
    satClr = 1'b0;
    satInValid = 1'b0;
    checks++;
    if (satTotal !== 3'd0 || satCorr !== 3'd0 || satUncorr !== 3'd0) begin
      errors++;
      $display("[TB] FAIL sat clear_at_handshake: got %0d/%0d/%0d, required 0/0/0",
               satTotal, satCorr, satUncorr);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_zero();
    test_correction();
    test_modes();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
